// File: rtl/shift_add_mul4_if.sv
// Handshake bundle for the 4x4 shift-add multiplier.
// Master issues start/a/b; slave answers with busy/done/product.
`timescale 1ns/1ps
interface shift_add_mul4_if;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/shift_add_mul4.sv
// Sequential 4x4 unsigned shift-add multiplier, IDLE/RUN/DONE FSM.
// Define SHIFT_ADD_MUL4_ZERO_SKIP_EN to bypass RUN for zero operands.
`timescale 1ns/1ps
module shift_add_mul4 (
    input  logic               clk,
    input  logic               rst_n,
    shift_add_mul4_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] mcand;
    logic [3:0] q;
    logic [3:0] acc;
    logic [1:0] cnt;
    logic       busy_r;
    logic       done_r;
    logic [7:0] prod_r;
    logic [4:0] sum;

    function automatic logic [4:0] ripple_add(
        input logic [3:0] x,
        input logic [3:0] y
    );
        logic [4:0] c;
        logic [3:0] s;
        c = '0;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        return {c[4], s};
    endfunction

    // {carry, sum}; passes acc through unchanged when q[0] is clear
    assign sum = ripple_add(acc, q[0] ? mcand : 4'd0);

`ifdef SHIFT_ADD_MUL4_ZERO_SKIP_EN
    logic zero_op;
    assign zero_op = (bus.a == 4'd0) || (bus.b == 4'd0);
`endif

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = prod_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            q      <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            prod_r <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand <= bus.a;
                        q     <= bus.b;
                        acc   <= '0;
                        cnt   <= '0;
`ifdef SHIFT_ADD_MUL4_ZERO_SKIP_EN
                        if (zero_op) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                            prod_r <= '0;
                        end else begin
                            state  <= RUN;
                            busy_r <= 1'b1;
                        end
`else
                        state  <= RUN;
                        busy_r <= 1'b1;
`endif
                    end
                end
                RUN: begin
                    acc <= sum[4:1];
                    q   <= {sum[0], q[3:1]};
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        prod_r <= {sum, q[3:1]};
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_r <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mul4.sv
// Scoreboard bench for shift_add_mul4: directed cases, reset abort,
// ignored restarts and an exhaustive 16x16 operand sweep.
`timescale 1ns/1ps
module tb_shift_add_mul4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   sb[$];

    shift_add_mul4_if m ();

    shift_add_mul4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge, idle again.
    task automatic run_op(
        input logic [3:0] a,
        input logic [3:0] b,
        input bit         hold
    );
        int n;
        int nbusy;
        int lat;
        int bcyc;
        int e;
        bit got;
        bit skip;
        skip = 1'b0;
`ifdef SHIFT_ADD_MUL4_ZERO_SKIP_EN
        skip = (a == 4'd0) || (b == 4'd0);
`endif
        lat  = skip ? 1 : 5;
        bcyc = skip ? 0 : 4;
        m.start = 1'b1;
        m.a = a;
        m.b = b;
        sb.push_back(int'(a) * int'(b));
        n = 0;
        nbusy = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (hold) begin
                m.a = 4'd3;
                m.b = 4'd3;
            end else begin
                m.start = 1'b0;
            end
            if (m.busy === 1'b1) nbusy++;
            if (m.done === 1'b1) got = 1'b1;
        end
        m.start = 1'b0;
        if (!got) begin
            chk("timeout", 0, 1);
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            chk("product", int'(m.product), e);
            chk("latency", n, lat);
            chk("busy_cycles", nbusy, bcyc);
            chk("busy_in_done", int'(m.busy), 0);
            @(negedge clk);
            chk("done_pulse", int'(m.done), 0);
        end
    endtask

    task automatic idle_hold(input int exp, input int cyc);
        for (int i = 0; i < cyc; i++) begin
            @(negedge clk);
            chk("held_product", int'(m.product), exp);
            chk("idle_done", int'(m.done), 0);
            chk("idle_busy", int'(m.busy), 0);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        m.start = 1'b0;
        m.a     = 4'd0;
        m.b     = 4'd0;
        #1;
        chk("rst_busy", int'(m.busy), 0);
        chk("rst_done", int'(m.done), 0);
        chk("rst_product", int'(m.product), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(4'd15, 4'd15, 1'b0);
        run_op(4'd10, 4'd12, 1'b0);
        idle_hold(120, 3);
        run_op(4'd1, 4'd1, 1'b0);
        idle_hold(1, 3);
        run_op(4'd0, 4'd9, 1'b0);
        idle_hold(0, 2);
        run_op(4'd9, 4'd0, 1'b0);

        // restart attempts during RUN/DONE must be dropped
        run_op(4'd7, 4'd5, 1'b1);
        idle_hold(35, 4);

        // reset mid-run aborts; no done afterwards
        m.start = 1'b1;
        m.a = 4'd15;
        m.b = 4'd15;
        @(posedge clk);
        @(negedge clk);
        m.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", int'(m.busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_busy", int'(m.busy), 0);
        chk("async_done", int'(m.done), 0);
        chk("async_product", int'(m.product), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_hold(0, 8);
        run_op(4'd2, 4'd3, 1'b0);

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run_op(4'(i), 4'(j), 1'b0);
            end
        end

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shift_add_mul4.md
SHIFT_ADD_MUL4 -- requirements
Module: shift_add_mul4

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 4 bits and product width at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request to multiply a by b; sampled only in IDLE.
REQ-005 a  input  4  multiplicand, unsigned; captured on accepted start.
REQ-006 b  input  4  multiplier, unsigned; captured on accepted start.
REQ-007 busy  output  1  high while an operation is in progress (RUN state).
REQ-008 done  output  1  one-cycle pulse: product valid.
REQ-009 product  output  8  unsigned a*b; held stable from done until next accepted start.

Function
REQ-010 FSM states SHALL be IDLE, RUN, DONE; reset state IDLE.
REQ-011 IDLE: start=1 at a rising edge SHALL be accepted: mcand<=a, q<=b, acc<=0 (5-bit: carry+4-bit sum), cnt<=0, state<=RUN.
REQ-012 IDLE: start=0 SHALL hold all registers; product keeps last result.
REQ-013 RUN, each edge: if q[0]=1, {c,s} = acc[3:0] + mcand with carry-in 0 via 4-bit ripple-carry add; else {c,s} = {0,acc[3:0]}.
REQ-014 RUN, same edge: {acc,q} <= {c,s,q} shifted right by one bit (c into acc[3], s[0] into q[3]); cnt <= cnt+1.
REQ-015 RUN SHALL last exactly 4 edges; on the edge where cnt=3, state<=DONE and product<={acc[3:0],q} after that edge's shift.
REQ-016 Latency: start accepted at edge 0 -> done=1 during the cycle after edge 4 -> edge 5 returns to IDLE.
REQ-017 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; never both.
REQ-018 start while in RUN or DONE SHALL be ignored (no restart, no queuing); a new start is accepted only at an edge in IDLE.
REQ-019 a, b changes after acceptance SHALL NOT affect the running operation.
REQ-020 Arithmetic SHALL be unsigned with no overflow: max 15*15=225 fits 8 bits; the adder carry is never lost.
REQ-021 product SHALL update only on entry to DONE; it SHALL NOT show partial results.

Reset
REQ-022 rst_n=0 SHALL immediately (no clock) force state=IDLE, busy=0, done=0, product=8'h00, acc, q, mcand, cnt = 0.
REQ-023 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow reset release.
REQ-024 After rst_n deasserts, the first edge SHALL behave as IDLE (start accepted if high).

Configuration
REQ-025 Macro SHIFT_ADD_MUL4_ZERO_SKIP_EN SHALL control a zero-operand shortcut.
REQ-026 With macro defined: accepted start with a=0 or b=0 SHALL go IDLE->DONE directly, product<=0, done in the cycle after edge 0, busy stays 0.
REQ-027 Without macro: every accepted start, including zero operands, SHALL take the full 4-edge RUN path per REQ-016.
REQ-028 Results SHALL be identical with and without the macro; only latency differs.

Verification
REQ-029 Reset, start=1 a=15 b=15 for one cycle -> busy=1 for 4 cycles, done pulse 1 cycle, product=8'hE1 (225).
REQ-030 a=10 b=12 -> product=8'h78 (120); a=1 b=1 -> 8'h01; product held through following IDLE cycles.
REQ-031 a=0 b=9 -> product=8'h00; done after 5 edges without macro, after 1 edge with SHIFT_ADD_MUL4_ZERO_SKIP_EN.
REQ-032 Start a=7 b=5, then start=1 with a=3 b=3 during RUN and DONE -> product=8'h23 (35), single done pulse, second request ignored.
REQ-033 Start a=15 b=15, assert rst_n=0 after 2 edges -> busy, done, product go 0 asynchronously; no done after release; next start a=2 b=3 -> 8'h06.
REQ-034 Exhaustive loop all 256 (a,b) pairs back-to-back (start raised in each IDLE) -> product=a*b every time.
